// File: rtl/funnel_shift_arbiter.sv
// Two-requester round-robin front end sharing one registered funnel shifter.
// A grant loads the result register. Grant and drain may happen on the same edge.
module funnel_shift_arbiter #(
    parameter int W     = 10,
    parameter int AMT_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_hi,
    input  logic [W-1:0]     req0_lo,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_hi,
    input  logic [W-1:0]     req1_lo,
    input  logic [AMT_W-1:0] req1_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_src,
    output logic             out_err,
    output logic [CNT_W-1:0] done_cnt
);

    logic [1:0]       req_valid;
    logic [W-1:0]     req_hi    [2];
    logic [W-1:0]     req_lo    [2];
    logic [AMT_W-1:0] req_amt   [2];
    logic [W-1:0]     shift_res [2];
    logic [1:0]       shift_err;

    assign req_valid  = {req1_valid, req0_valid};
    assign req_hi[0]  = req0_hi;
    assign req_hi[1]  = req1_hi;
    assign req_lo[0]  = req0_lo;
    assign req_lo[1]  = req1_lo;
    assign req_amt[0] = req0_amt;
    assign req_amt[1] = req1_amt;

    // Both shifters are evaluated in parallel; only the granted one is registered.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_shift
            logic [2*W-1:0] funnel;
            logic [W-1:0]   shifted;
            assign funnel         = {req_hi[gi], req_lo[gi]};
            assign shifted        = W'(funnel >> req_amt[gi]);
            assign shift_err[gi]  = (32'(req_amt[gi]) > 32'(W));
            assign shift_res[gi]  = shift_err[gi] ? '0 : shifted;
        end
    endgenerate

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q,  out_data_d;
    logic             out_src_q,   out_src_d;
    logic             out_err_q,   out_err_d;
    logic             rr_q,        rr_d;
    logic [CNT_W-1:0] done_cnt_q,  done_cnt_d;

    logic       can_accept;
    logic [1:0] grant;
    logic       fire;
    logic       gsel;

    assign can_accept = !out_valid_q | out_ready;
    assign grant[0]   = req_valid[0] & (!req_valid[1] | !rr_q);
    assign grant[1]   = req_valid[1] & (!req_valid[0] |  rr_q);
    // rst_n gating keeps both readys low for the whole reset interval.
    assign fire       = can_accept & rst_n & (|grant);
    assign gsel       = grant[1];
    assign req0_ready = can_accept & rst_n & grant[0];
    assign req1_ready = can_accept & rst_n & grant[1];

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_err_d   = out_err_q;
        rr_d        = rr_q;
        done_cnt_d  = done_cnt_q;
        if (out_valid_q && out_ready) begin
            done_cnt_d = done_cnt_q + CNT_W'(1);
        end
        if (fire) begin
            out_valid_d = 1'b1;
            out_data_d  = shift_res[gsel];
            out_src_d   = gsel;
            out_err_d   = shift_err[gsel];
            rr_d        = ~gsel;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            out_err_q   <= 1'b0;
            rr_q        <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_err_q   <= out_err_d;
            rr_q        <= rr_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_err   = out_err_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: doc/funnel_shift_arbiter.md
# funnel_shift_arbiter

Shares a single registered 10-bit funnel-shift stage between two requesters using round-robin arbitration. Each requester presents a high word, a low word and a shift amount on a valid/ready port. The granted request is shifted and registered, then presented on one valid/ready output port tagged with its source. The block sits between the two issue units and the downstream consumer, and replaces the duplicated shifters those units would otherwise carry.

## Interface
- W, 10, data width of hi/lo words and result
- AMT_W, 4, width of shift amount
- CNT_W, 16, width of the completed-operation counter
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_hi  input  W  upper word of funnel
- req0_lo  input  W  lower word of funnel
- req0_amt  input  AMT_W  right-shift amount
- req1_valid, req1_ready, req1_hi, req1_lo, req1_amt: same as requester 0
- out_valid  output  1  result register holds a result
- out_ready  input  1  consumer accepts result
- out_data  output  W  shifted result
- out_src  output  1  requester index that produced out_data
- out_err  output  1  amount was out of range (> W)
- done_cnt  output  CNT_W  count of results consumed (out_valid & out_ready)

## Operation
- Funnel: f = {hi, lo} (2W bits). Result = (f >> amt)[W-1:0].
- amt = 0 gives lo. amt = W gives hi. For 0 < amt < W, the result is lo shifted right by amt, with the upper amt bits filled from hi[amt-1:0].
- amt > W: result 0 and out_err = 1. The request is still accepted, counted and routed normally.
- can_accept = !out_valid | out_ready. No request is granted when can_accept = 0.
- Arbitration uses priority pointer rr (1 bit).
  - Only one valid requester: that requester is granted.
  - Both valid: requester rr is granted.
- reqX_ready = can_accept & grantX. reqX_ready depends combinationally on both valids, rr, out_valid and out_ready. Requesters must not make valid depend on ready.
- When any grant occurs, rr is set to the index of the requester that was not granted. When no grant occurs, rr holds.
- A requester must hold valid and its payload stable until ready. The block does not register unaccepted requests.
- On grant, out_data, out_src and out_err load, and out_valid is set to 1.
- When the result is consumed with no new grant, out_valid clears and out_data, out_src and out_err hold their values.
- done_cnt increments by 1 on every out_valid & out_ready and wraps modulo 2^CNT_W.

## Timing
- Reset (rst_n = 0, asynchronous): out_valid = 0, out_data = 0, out_src = 0, out_err = 0, rr = 0, done_cnt = 0. While reset is asserted, req0_ready = req1_ready = 0.
- Reset mid-operation discards the held result with no output handshake. After release, the first grant follows normal rules with rr = 0.
- Latency: a request accepted on edge N has out_valid = 1 after edge N, i.e. visible in cycle N+1.
- Throughput: 1 result per cycle while out_ready = 1. Accepting a new request and draining the current result happen on the same edge (pipeline pass-through).
- Backpressure: when out_valid = 1 and out_ready = 0, both readys = 0 and the output payload holds stable.
- Both requesters continuously valid with out_ready = 1: grants alternate 0, 1, 0, 1 starting from the reset rr = 0.
- Simultaneous consume and grant on the same edge: done_cnt increments and the register loads the new result. out_valid stays 1.

## Test plan
- Reset, then req0 only: hi = 0x3FF, lo = 0x000, amt = 3, out_ready = 1 -> next cycle out_valid = 1, out_data = 0x380, out_src = 0, out_err = 0, done_cnt = 1 after the consuming edge.
- Amount sweep on req1: hi = 0x2AA, lo = 0x155 for amt = 0, 5, 10, 11 -> out_data = 0x155, 0x14A, 0x2AA, 0x000. out_err = 1 only for amt = 11.
- Both requesters held valid for 6 cycles with out_ready = 1 -> out_src sequence 0, 1, 0, 1, 0, 1, one result per cycle, done_cnt = 6.
- Backpressure: out_ready = 0 for 4 cycles with both valid -> both readys = 0, out_data and out_src stable. When out_ready rises, the next grant goes to the requester opposite the held out_src.
- Reset asserted while out_valid = 1 and out_ready = 0 -> all outputs and done_cnt return to 0 immediately (asynchronously). After release, with both valid, req0 is granted first.
- Counter wrap: with CNT_W = 4, stream 17 results -> done_cnt = 1.
